id_scoreboard: RTL and testbench

ID_SCOREBOARD -- requirements
Module: id_scoreboard

---
 rtl/id_scoreboard.sv | 100 ++++++++++
 tb/tb_id_scoreboard.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
// Register-hazard scoreboard: per-register in-flight write counters gating instruction issue.
// Tracks RAW hazards on sources, saturation on destinations, and flush/underflow conditions.
module id_scoreboard #(
  parameter int unsigned REGADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH     = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               issue_valid,
  input  logic [REGADDR_WIDTH-1:0]           issue_rs_addr,
  input  logic [REGADDR_WIDTH-1:0]           issue_rt_addr,
  input  logic                               issue_rs_used,
  input  logic                               issue_rt_used,
  input  logic [REGADDR_WIDTH-1:0]           issue_wb_addr,
  output logic                               issue_ready,
  input  logic                               retire_valid,
  input  logic [REGADDR_WIDTH-1:0]           retire_addr,
  input  logic                               flush,
  output logic [2**REGADDR_WIDTH-1:0]        busy_mask,
  output logic [REGADDR_WIDTH+CNT_WIDTH-1:0] inflight_total,
  output logic [31:0]                        stall_cycles,
  output logic                               underflow_err
);

  localparam int unsigned NumRegs = 2 ** REGADDR_WIDTH;
  localparam int unsigned TotW    = REGADDR_WIDTH + CNT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};

  logic [NumRegs-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]                       stall_q, stall_d;
  logic                              err_q, err_d;
  logic                              issue_fire;
  logic                              rs_hazard, rt_hazard, wb_full;

  // Hazards look only at registered counters; same-cycle retires do not bypass.
  always_comb begin
    rs_hazard   = issue_rs_used && (issue_rs_addr != '0) && (cnt_q[issue_rs_addr] != '0);
    rt_hazard   = issue_rt_used && (issue_rt_addr != '0) && (cnt_q[issue_rt_addr] != '0);
    wb_full     = (issue_wb_addr != '0) && (cnt_q[issue_wb_addr] == CntMax);
    issue_ready = !flush && !rs_hazard && !rt_hazard && !wb_full;
    issue_fire  = issue_valid && issue_ready;
  end

  always_comb begin
    logic inc, ret;
    cnt_d    = cnt_q;
    err_d    = err_q;
    cnt_d[0] = '0;
    for (int unsigned i = 1; i < NumRegs; i++) begin
      inc = issue_fire && (issue_wb_addr == REGADDR_WIDTH'(i));
      ret = retire_valid && (retire_addr == REGADDR_WIDTH'(i));
      if (inc && !ret) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (ret && !inc) begin
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end
    if (flush) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (issue_valid && !issue_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    logic [TotW-1:0] sum;
    sum       = '0;
    busy_mask = '0;
    for (int unsigned i = 1; i < NumRegs; i++) begin
      busy_mask[i] = (cnt_q[i] != '0);
      sum          = sum + TotW'(cnt_q[i]);
    end
    inflight_total = sum;
  end

  assign stall_cycles  = stall_q;
  assign underflow_err = err_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed scoreboard bench for id_scoreboard: stimulus queues expected observations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_id_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rs_addr = '0, issue_rt_addr = '0, issue_wb_addr = '0;
  logic        issue_rs_used = 1'b0, issue_rt_used = 1'b0;
  logic        issue_ready;
  logic        retire_valid = 1'b0;
  logic [4:0]  retire_addr = '0;
  logic        flush = 1'b0;
  logic [31:0] busy_mask;
  logic [6:0]  inflight_total;
  logic [31:0] stall_cycles;
  logic        underflow_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic        rdy;
    logic [31:0] busy;
    logic [6:0]  tot;
    logic [31:0] stall;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  id_scoreboard #(.REGADDR_WIDTH(5), .CNT_WIDTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_rs_addr  (issue_rs_addr),
    .issue_rt_addr  (issue_rt_addr),
    .issue_rs_used  (issue_rs_used),
    .issue_rt_used  (issue_rt_used),
    .issue_wb_addr  (issue_wb_addr),
    .issue_ready    (issue_ready),
    .retire_valid   (retire_valid),
    .retire_addr    (retire_addr),
    .flush          (flush),
    .busy_mask      (busy_mask),
    .inflight_total (inflight_total),
    .stall_cycles   (stall_cycles),
    .underflow_err  (underflow_err)
  );

  always #5 clk = ~clk;

  // Monitor: one queued observation per cycle, compared at the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total += 5;
      if (issue_ready !== e.rdy) begin
        bad++;
        $display("FAIL %s ready: got %0b want %0b", e.name, issue_ready, e.rdy);
      end
      if (busy_mask !== e.busy) begin
        bad++;
        $display("FAIL %s busy_mask: got %h want %h", e.name, busy_mask, e.busy);
      end
      if (inflight_total !== e.tot) begin
        bad++;
        $display("FAIL %s inflight_total: got %0d want %0d", e.name, inflight_total, e.tot);
      end
      if (stall_cycles !== e.stall) begin
        bad++;
        $display("FAIL %s stall_cycles: got %0d want %0d", e.name, stall_cycles, e.stall);
      end
      if (underflow_err !== e.err) begin
        bad++;
        $display("FAIL %s underflow_err: got %0b want %0b", e.name, underflow_err, e.err);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                     input logic rtu, input logic [4:0] wb, input logic rv, input logic [4:0] ra,
                     input logic fl);
    issue_valid   = v;
    issue_rs_addr = rs;
    issue_rs_used = rsu;
    issue_rt_addr = rt;
    issue_rt_used = rtu;
    issue_wb_addr = wb;
    retire_valid  = rv;
    retire_addr   = ra;
    flush         = fl;
  endtask

  task automatic chk(input string name, input logic rdy, input logic [31:0] busy,
                     input logic [6:0] tot, input logic [31:0] stall, input logic err);
    exp_t e;
    e.name  = name;
    e.rdy   = rdy;
    e.busy  = busy;
    e.tot   = tot;
    e.stall = stall;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 1'b1, 32'h0, 7'd0, 32'd0, 1'b0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("reset_flush", 1'b0, 32'h0, 7'd0, 32'd0, 1'b0);
    step();
    rst = 1'b0;
    // RAW on rs=5, retire does not bypass, stall count reaches 2
    drv(1, 0, 0, 0, 0, 5, 0, 0, 0);  chk("issue_wb5",   1, 32'h0,  7'd0, 32'd0, 0); step();
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0);  chk("raw_rs5",     0, 32'h20, 7'd1, 32'd0, 0); step();
    drv(1, 5, 1, 0, 0, 0, 1, 5, 0);  chk("raw_retire",  0, 32'h20, 7'd1, 32'd1, 0); step();
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0);  chk("raw_cleared", 1, 32'h0,  7'd0, 32'd2, 0); step();
    // Saturation on wb=7
    drv(1, 0, 0, 0, 0, 7, 0, 0, 0);  chk("waw7_a",      1, 32'h0,  7'd0, 32'd2, 0); step();
    chk("waw7_b", 1, 32'h80, 7'd1, 32'd2, 0); step();
    chk("waw7_c", 1, 32'h80, 7'd2, 32'd2, 0); step();
    chk("sat7",   0, 32'h80, 7'd3, 32'd2, 0); step();
    drv(1, 0, 0, 0, 0, 7, 1, 7, 0);  chk("sat7_ret",    0, 32'h80, 7'd3, 32'd3, 0); step();
    drv(1, 0, 0, 0, 0, 7, 0, 0, 0);  chk("unsat7",      1, 32'h80, 7'd2, 32'd4, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);  chk("refill7",     1, 32'h80, 7'd3, 32'd4, 0); step();
    // Simultaneous issue and retire on register 9
    drv(1, 0, 0, 0, 0, 9, 0, 0, 0);  chk("issue9",      1, 32'h80,  7'd3, 32'd4, 0); step();
    drv(1, 0, 0, 0, 0, 9, 1, 9, 0);  chk("iss_ret9",    1, 32'h280, 7'd4, 32'd4, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);  chk("hold9",       1, 32'h280, 7'd4, 32'd4, 0); step();
    // Retire to register 0 is ignored, retire to idle register 4 flags underflow
    drv(0, 0, 0, 0, 0, 0, 1, 0, 0);  chk("ret0",        1, 32'h280, 7'd4, 32'd4, 0); step();
    drv(0, 0, 0, 0, 0, 0, 1, 4, 0);  chk("ret4",        1, 32'h280, 7'd4, 32'd4, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);  chk("underflow",   1, 32'h280, 7'd4, 32'd4, 1); step();
    // Flush overrides simultaneous issue
    drv(1, 0, 0, 0, 0, 3, 0, 0, 0);  chk("issue3",      1, 32'h280,  7'd4, 32'd4, 1); step();
    drv(1, 0, 0, 0, 0, 8, 0, 0, 0);  chk("issue8",      1, 32'h288,  7'd5, 32'd4, 1); step();
    drv(1, 0, 0, 0, 0, 12, 0, 0, 0); chk("issue12",     1, 32'h388,  7'd6, 32'd4, 1); step();
    drv(1, 0, 0, 0, 0, 3, 0, 0, 1);  chk("flush",       0, 32'h1388, 7'd7, 32'd4, 1); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);  chk("post_flush",  1, 32'h0,    7'd0, 32'd5, 1); step();
    // Register 0 and unused rt never hazard
    drv(1, 0, 0, 0, 0, 6, 0, 0, 0);  chk("issue6",      1, 32'h0,  7'd0, 32'd5, 1); step();
    drv(1, 0, 1, 6, 0, 0, 0, 0, 0);  chk("rt_unused",   1, 32'h40, 7'd1, 32'd5, 1); step();
    drv(1, 0, 0, 6, 1, 0, 0, 0, 0);  chk("raw_rt6",     0, 32'h40, 7'd1, 32'd5, 1); step();
    // Asynchronous reset pulse between edges
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    chk("async_rst", 1, 32'h0, 7'd0, 32'd0, 0);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
